// File: rtl/counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown_mod
// Brief    : Parametrised up/down modulo counter with load, wrap/saturate mode,
//            registered terminal-count pulse and sticky overflow flag.
//            Optional prescaler built when COUNTER_PRESCALE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module counter_updown_mod #(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
      MODULUS > (longint'(1) << WIDTH) || PRESCALE < 1) begin : g_param_err
    $error("counter_updown_mod: illegal parameter set");
  end

  localparam logic [WIDTH:0]   c_mod = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic             w_tick;
  logic             w_step;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH:0]   w_ld;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_boundary;
  logic [WIDTH-1:0] w_step_val;
  logic [WIDTH-1:0] w_load_val;

`ifdef COUNTER_PRESCALE_EN
  localparam int c_pw = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_pw-1:0] c_pre_last = c_pw'(PRESCALE - 1);

  logic [c_pw-1:0] r_pre;

  assign w_tick = (r_pre == c_pre_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (load) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // One extra bit keeps the modulus compare and the borrow free of 2^WIDTH wrap.
  assign w_inc    = {1'b0, r_count} + 1'b1;
  assign w_dec    = {1'b0, r_count} - 1'b1;
  assign w_ld     = {1'b0, load_val};
  assign w_at_top = (w_inc == c_mod);
  assign w_at_bot = w_dec[WIDTH];

  assign w_step     = en && w_tick;
  assign w_boundary = w_step && (up ? w_at_top : w_at_bot);

  always_comb begin
    w_step_val = r_count;
    if (up) begin
      if (w_at_top) w_step_val = sat ? c_max : '0;
      else          w_step_val = w_inc[WIDTH-1:0];
    end else begin
      if (w_at_bot) w_step_val = sat ? '0 : c_max;
      else          w_step_val = w_dec[WIDTH-1:0];
    end
  end

  assign w_load_val = (w_ld >= c_mod) ? c_max : load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (load) begin
      r_count <= w_load_val;
      r_tc    <= 1'b0;
      r_ovf   <= r_ovf & ~clr_ovf;
    end else begin
      if (w_step) r_count <= w_step_val;
      r_tc  <= w_boundary;
      r_ovf <= w_boundary | (r_ovf & ~clr_ovf);
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised up/down modulo counter, the next generation of the sequential 4-bit counter in the benchmark's sequential dataset. It adds configurable width and modulus, direction control, synchronous parallel load, a wrap or saturate mode, a registered terminal-count pulse and a sticky overflow flag. Its defaults (WIDTH=4, MODULUS=16, up, wrap) reproduce the legacy 4-bit counter behaviour on clk/rst/en/count, so existing stimulus keeps working.

## Interface
- WIDTH, 4: counter width in bits; legal range is 1 to 32.
- MODULUS, 16: count range is 0 to MODULUS-1; legal range is 2 ≤ MODULUS ≤ 2^WIDTH.
- PRESCALE, 1: enabled cycles per count step; ≥ 1; used only with COUNTER_PRESCALE_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat  in  1  mode: 0 = wrap at boundaries, 1 = saturate at boundaries.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- clr_ovf  in  1  clears the sticky ovf flag.
- count  out  WIDTH  current count.
- tc  out  1  registered one-cycle terminal-count pulse.
- ovf  out  1  sticky boundary-event flag.

## Operation
- Per-edge priority: rst > load > en. With none of them active, all state holds.
- Load:
  - count <= min(load_val, MODULUS-1), so out-of-range values clamp to MODULUS-1.
  - Load never raises tc or ovf and clears the prescaler.
- Step up:
  - count < MODULUS-1: count+1.
  - count == MODULUS-1, sat=0: wraps to 0.
  - count == MODULUS-1, sat=1: holds at MODULUS-1.
- Step down:
  - count > 0: count-1.
  - count == 0, sat=0: wraps to MODULUS-1.
  - count == 0, sat=1: holds at 0.
- Boundary event: a step taken from the boundary in the current direction, in either mode. It sets tc=1 for exactly the next cycle and sets ovf.
- ovf:
  - Sticky; cleared by clr_ovf.
  - clr_ovf together with a boundary event in the same cycle: ovf=1 (set wins).
- Arithmetic:
  - Internal next-value computation is WIDTH+1 bits wide, so no unintended 2^WIDTH wrap occurs.
  - When MODULUS=2^WIDTH, behaviour is identical to natural rollover.
- up and sat may change on any cycle; they take effect on the next enabled step.
- Reset asserted mid-operation clears everything immediately. When it is released, counting resumes from 0 on the first edge with en=1.

## Timing
- All outputs are registered.
- Reset values: count=0, tc=0, ovf=0, prescaler=0.
- Asynchronous reset acts on rst rising with no clock edge needed. Release is synchronous to the clk domain.
- Latency:
  - en sampled at edge N drives the new count after edge N.
  - tc is high from edge N to edge N+1 for a boundary event at edge N.
- Back-to-back boundary events (e.g. MODULUS=2 with en held): tc stays high on consecutive cycles.
- load at edge N: count = clamped value after edge N; tc=0 after edge N.

## Configuration
- COUNTER_PRESCALE_EN defined:
  - An internal prescaler counts en=1 cycles from 0 to PRESCALE-1.
  - count steps only on the enabled cycle where the prescaler equals PRESCALE-1, after which the prescaler returns to 0.
  - en=0 freezes the prescaler.
  - rst or load clears the prescaler.
  - PRESCALE=1 behaves as if undefined.
- COUNTER_PRESCALE_EN undefined:
  - No prescaler logic is built and PRESCALE is ignored.
  - Every cycle with en=1 is a step.

## Test plan
- Reset:
  - Sequence: count to 7 with en=1, assert rst between clock edges.
  - Required: count=0, tc=0, ovf=0 before the next edge; after release plus 2 enabled edges, count=2.
- Wrap up (MODULUS=10):
  - Sequence: load 9, then en=1 up=1 sat=0 for 1 cycle.
  - Required: count=0, tc=1 for one cycle, ovf=1; 1 more cycle gives count=1, tc=0, ovf=1.
- Saturate down:
  - Sequence: load 0, en=1 up=0 sat=1 for 3 cycles.
  - Required: count=0 throughout, tc high 3 cycles, ovf=1.
  - Then up=1 for 2 cycles: count=2, tc=0.
- Load priority and clamp (MODULUS=10):
  - Sequence: load_val=12 with load=1 and en=1 in the same cycle.
  - Required: count=9, tc=0.
  - Then load_val=3, load=1: count=3.
- ovf set/clear race:
  - Sequence: count at 15 (defaults), en=1 up=1 with clr_ovf=1 in the same cycle.
  - Required: count=0, ovf=1.
  - Next cycle clr_ovf=1, en=0: ovf=0.
- Prescale (COUNTER_PRESCALE_EN, PRESCALE=3):
  - Sequence: en=1 for 7 cycles from reset.
  - Required: count=2.
  - Then en=0 for 5 cycles followed by en=1 for 1 cycle: count=2; 2 more enabled cycles give count=3.
